// File: rtl/holy_irq_pkg.sv
// Shared definitions for the Holy Core external-interrupt controller.
// Contents: register byte offsets, AXI response codes and a byte-strobe
// expansion helper used by the register write path.
package holy_irq_pkg;

   // Register byte offsets. Only address bits [4:2] are decoded.
   localparam logic [4:0] PENDING_OFF  = 5'h00;
   localparam logic [4:0] ENABLE_OFF   = 5'h04;
   localparam logic [4:0] MODE_OFF     = 5'h08;
   localparam logic [4:0] POLARITY_OFF = 5'h0C;
   localparam logic [4:0] CLAIM_OFF    = 5'h10;
   localparam logic [4:0] RAW_OFF      = 5'h14;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Expand a 4-bit byte strobe into a 32-bit bit mask.
   function automatic logic [31:0] strb_mask(input logic [3:0] strb);
      logic [31:0] m;
      for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{strb[b]}};
      return m;
   endfunction

endpackage

// File: rtl/holy_irq_ctrl_if.sv
// AXI-Lite register port of the interrupt controller.
// master: drives aw/w/ar channels and bready/rready.
// slave : drives awready/wready, b channel, arready and r channel.
interface holy_irq_ctrl_if #(
   parameter int ADDR_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0] awaddr;
   logic                  awvalid;
   logic                  awready;
   logic [31:0]           wdata;
   logic [3:0]            wstrb;
   logic                  wvalid;
   logic                  wready;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;
   logic [ADDR_WIDTH-1:0] araddr;
   logic                  arvalid;
   logic                  arready;
   logic [31:0]           rdata;
   logic [1:0]            rresp;
   logic                  rvalid;
   logic                  rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/holy_irq_sync.sv
// Multi-flop synchroniser for the raw interrupt lines.
// Ports: clk, rst_n (async active-low), d = raw asynchronous lines,
//        q = lines after SYNC_STAGES flops.
module holy_irq_sync #(
   parameter int NUM_IRQ     = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_IRQ-1:0] d,
   output logic [NUM_IRQ-1:0] q
);
   logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] chain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) chain <= '0;
      else        chain <= {chain[SYNC_STAGES-2:0], d};
   end

   assign q = chain[SYNC_STAGES-1];
endmodule

// File: rtl/holy_irq_ctrl.sv
// External-interrupt controller feeding the Holy Core machine-external
// interrupt. Each line is synchronised, optionally inverted, and either
// passed through as a level or captured as a rising edge into PENDING.
// Ports: clk, rst_n (async active-low), irq_in[NUM_IRQ] raw lines,
//        irq_out registered OR of pending & enable,
//        s_axi_lite AXI-Lite slave (PENDING/ENABLE/MODE/POLARITY/CLAIM/RAW).
module holy_irq_ctrl
   import holy_irq_pkg::*;
#(
   parameter int NUM_IRQ     = 8,
   parameter int SYNC_STAGES = 2,
   parameter int ADDR_WIDTH  = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_IRQ-1:0] irq_in,
   output logic               irq_out,
   holy_irq_ctrl_if.slave     s_axi_lite
);
   logic [NUM_IRQ-1:0]    sync_q, s, s_prev, set, pend_q, pending;
   logic [NUM_IRQ-1:0]    enable_q, mode_q, pol_q;
   logic [NUM_IRQ-1:0]    wmask, wbits, w1c, claim_oh, claim_clr;
   logic [31:0]           mask32, data32, claim_val, rd_word;
   logic [ADDR_WIDTH-1:0] aw_addr, ar_addr;
   logic [4:0]            w_off, r_off;
   logic                  live_q, w_hs, ar_hs, w_mapped, rd_err;
   logic                  bvalid_q, rvalid_q;
   logic [1:0]            bresp_q, rresp_q;
   logic [31:0]           rdata_q;
   logic                  unused_ok;

   holy_irq_sync #(.NUM_IRQ(NUM_IRQ), .SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (irq_in),
      .q     (sync_q)
   );

   // Line path: polarity-corrected level, rising-edge detect, and the
   // visible pending view (level lines bypass the pending flops).
   assign s       = sync_q ^ pol_q;
   assign set     = s & ~s_prev;
   assign pending = (mode_q & pend_q) | (~mode_q & s);

   // Lowest-index enabled pending line wins the claim.
   always_comb begin
      claim_oh  = '0;
      claim_val = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (pending[i] && enable_q[i]) begin
            claim_oh    = '0;
            claim_oh[i] = 1'b1;
            claim_val   = 32'(i + 1);
         end
      end
   end

   // AXI-Lite decode. live_q keeps both channels quiet in the first cycle
   // after reset so no ready is seen while the block is still in reset.
   assign aw_addr  = s_axi_lite.awaddr;
   assign ar_addr  = s_axi_lite.araddr;
   assign w_off    = {aw_addr[4:2], 2'b00};
   assign r_off    = {ar_addr[4:2], 2'b00};
   assign w_mapped = (w_off <= RAW_OFF);
   assign w_hs     = live_q & s_axi_lite.awvalid & s_axi_lite.wvalid & ~bvalid_q;
   assign ar_hs    = live_q & s_axi_lite.arvalid & ~rvalid_q;

   assign mask32 = strb_mask(s_axi_lite.wstrb);
   assign data32 = s_axi_lite.wdata & mask32;
   assign wmask  = mask32[NUM_IRQ-1:0];
   assign wbits  = data32[NUM_IRQ-1:0];

   // W1C and claim clear are OR-ed; a same-cycle edge still sets the bit.
   assign w1c       = (w_hs && (w_off == PENDING_OFF)) ? wbits : '0;
   assign claim_clr = (ar_hs && (r_off == CLAIM_OFF)) ? (claim_oh & mode_q) : '0;

   always_comb begin
      rd_word = '0;
      rd_err  = 1'b0;
      case (r_off)
         PENDING_OFF:  rd_word = 32'(pending);
         ENABLE_OFF:   rd_word = 32'(enable_q);
         MODE_OFF:     rd_word = 32'(mode_q);
         POLARITY_OFF: rd_word = 32'(pol_q);
         CLAIM_OFF:    rd_word = claim_val;
         RAW_OFF:      rd_word = 32'(sync_q);
         default:      rd_err  = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         live_q   <= 1'b0;
         s_prev   <= '0;
         pend_q   <= '0;
         enable_q <= '0;
         mode_q   <= '0;
         pol_q    <= '0;
         irq_out  <= 1'b0;
         bvalid_q <= 1'b0;
         bresp_q  <= RESP_OKAY;
         rvalid_q <= 1'b0;
         rresp_q  <= RESP_OKAY;
         rdata_q  <= '0;
      end else begin
         live_q  <= 1'b1;
         s_prev  <= s;
         pend_q  <= mode_q & ((pend_q & ~w1c & ~claim_clr) | set);
         irq_out <= |(pending & enable_q);

         if (w_hs) begin
            case (w_off)
               ENABLE_OFF:   enable_q <= (enable_q & ~wmask) | wbits;
               MODE_OFF:     mode_q   <= (mode_q & ~wmask) | wbits;
               POLARITY_OFF: pol_q    <= (pol_q & ~wmask) | wbits;
               default: ;
            endcase
            bvalid_q <= 1'b1;
            bresp_q  <= w_mapped ? RESP_OKAY : RESP_SLVERR;
         end else if (s_axi_lite.bready) begin
            bvalid_q <= 1'b0;
         end

         if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_word;
            rresp_q  <= rd_err ? RESP_SLVERR : RESP_OKAY;
         end else if (s_axi_lite.rready) begin
            rvalid_q <= 1'b0;
         end
      end
   end

   assign s_axi_lite.awready = w_hs;
   assign s_axi_lite.wready  = w_hs;
   assign s_axi_lite.bvalid  = bvalid_q;
   assign s_axi_lite.bresp   = bresp_q;
   assign s_axi_lite.arready = live_q & ~rvalid_q;
   assign s_axi_lite.rvalid  = rvalid_q;
   assign s_axi_lite.rresp   = rresp_q;
   assign s_axi_lite.rdata   = rdata_q;

   // Address bits outside [4:2] and data bits above the line count are
   // intentionally ignored.
   assign unused_ok = ^{data32, mask32, aw_addr, ar_addr};
endmodule

// File: tb/tb_holy_irq_ctrl.sv
module tb_holy_irq_ctrl;
   import holy_irq_pkg::*;

   localparam int N = 8;
   localparam int S = 2;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] irq_in = '0;
   logic         irq_out;

   holy_irq_ctrl_if #(.ADDR_WIDTH(8)) bus ();

   holy_irq_ctrl #(.NUM_IRQ(N), .SYNC_STAGES(S), .ADDR_WIDTH(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .irq_in     (irq_in),
      .irq_out    (irq_out),
      .s_axi_lite (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [N-1:0] hist [S];          // hist[0] = newest sample of irq_in
   logic [N-1:0] m_en, m_mode, m_pol, m_pend, m_sprev;
   logic         m_irq, m_live, m_bvalid, m_rvalid;
   logic [1:0]   m_bresp, m_rresp;
   logic [31:0]  m_rdata;

   task automatic model_reset();
      for (int j = 0; j < S; j++) hist[j] = '0;
      m_en = '0; m_mode = '0; m_pol = '0; m_pend = '0; m_sprev = '0;
      m_irq = 1'b0; m_live = 1'b0; m_bvalid = 1'b0; m_rvalid = 1'b0;
      m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = '0;
   endtask

   task automatic model_step();
      logic [N-1:0] s, pend, clr, nen, nmode, npol, npend;
      logic [31:0]  wm, wd, val;
      logic         rd, wr, irq_n;
      int           off;
      s = hist[S-1] ^ m_pol;
      for (int i = 0; i < N; i++) pend[i] = m_mode[i] ? m_pend[i] : s[i];
      irq_n = |(pend & m_en);
      clr = '0;
      nen = m_en; nmode = m_mode; npol = m_pol;
      rd = m_live && bus.arvalid && !m_rvalid;
      wr = m_live && bus.awvalid && bus.wvalid && !m_bvalid;
      if (rd) begin
         off = int'({bus.araddr[4:2], 2'b00});
         val = '0;
         m_rresp = 2'b00;
         case (off)
            'h00: val = 32'(pend);
            'h04: val = 32'(m_en);
            'h08: val = 32'(m_mode);
            'h0C: val = 32'(m_pol);
            'h10: for (int i = 0; i < N; i++)
                     if (pend[i] && m_en[i] && val == 0) begin
                        val = 32'(i + 1);
                        if (m_mode[i]) clr[i] = 1'b1;
                     end
            'h14: val = 32'(hist[S-1]);
            default: m_rresp = 2'b10;
         endcase
         m_rdata = val;
         m_rvalid = 1'b1;
      end else if (m_rvalid && bus.rready) m_rvalid = 1'b0;
      if (wr) begin
         for (int b = 0; b < 4; b++) wm[8*b +: 8] = bus.wstrb[b] ? 8'hFF : 8'h00;
         wd = bus.wdata & wm;
         off = int'({bus.awaddr[4:2], 2'b00});
         m_bresp = 2'b00;
         case (off)
            'h00: clr = clr | wd[N-1:0];
            'h04: nen   = (m_en & ~wm[N-1:0]) | wd[N-1:0];
            'h08: nmode = (m_mode & ~wm[N-1:0]) | wd[N-1:0];
            'h0C: npol  = (m_pol & ~wm[N-1:0]) | wd[N-1:0];
            'h10, 'h14: ;
            default: m_bresp = 2'b10;
         endcase
         m_bvalid = 1'b1;
      end else if (m_bvalid && bus.bready) m_bvalid = 1'b0;
      // Edge lines: a new rising edge always sets; otherwise clear if asked.
      for (int i = 0; i < N; i++) begin
         if (!m_mode[i])                 npend[i] = 1'b0;
         else if (s[i] && !m_sprev[i])   npend[i] = 1'b1;
         else                            npend[i] = m_pend[i] && !clr[i];
      end
      m_pend = npend; m_en = nen; m_mode = nmode; m_pol = npol;
      m_sprev = s; m_irq = irq_n; m_live = 1'b1;
      for (int j = S - 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = irq_in;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk);
         if (!rst_n) model_reset();
         else        model_step();
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         check("irq_out", 32'(irq_out), 32'(m_irq));
         check("awready", 32'(bus.awready), 32'(m_live & bus.awvalid & bus.wvalid & ~m_bvalid));
         check("wready", 32'(bus.wready), 32'(m_live & bus.awvalid & bus.wvalid & ~m_bvalid));
         check("arready", 32'(bus.arready), 32'(m_live & ~m_rvalid));
         check("bvalid", 32'(bus.bvalid), 32'(m_bvalid));
         check("rvalid", 32'(bus.rvalid), 32'(m_rvalid));
         if (m_bvalid) check("bresp", 32'(bus.bresp), 32'(m_bresp));
         if (m_rvalid) begin
            check("rdata", bus.rdata, m_rdata);
            check("rresp", 32'(bus.rresp), 32'(m_rresp));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int hold, output logic [1:0] resp);
      int n;
      bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!bus.awready && n < 20) begin @(negedge clk); n++; end
      if (!bus.awready) begin
         checks++; errors++;
         $display("FAIL write_timeout: no awready for addr %0h", addr);
      end
      @(posedge clk); #2;
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      repeat (hold) tick();
      check("bvalid_held", 32'(bus.bvalid), 32'd1);
      resp = bus.bresp;
      bus.bready = 1'b1;
      tick();
      bus.bready = 1'b0;
   endtask

   task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
      int n;
      bus.araddr = addr; bus.arvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!bus.arready && n < 20) begin @(negedge clk); n++; end
      if (!bus.arready) begin
         checks++; errors++;
         $display("FAIL read_timeout: no arready for addr %0h", addr);
      end
      @(posedge clk); #2;
      bus.arvalid = 1'b0;
      check("rvalid_up", 32'(bus.rvalid), 32'd1);
      data = bus.rdata;
      resp = bus.rresp;
      bus.rready = 1'b1;
      tick();
      bus.rready = 1'b0;
   endtask

   task automatic wr(input logic [7:0] addr, input logic [31:0] data);
      logic [1:0] r;
      axi_write(addr, data, 4'hF, 0, r);
      check("wr_resp", 32'(r), 32'(RESP_OKAY));
   endtask

   task automatic rd(input string name, input logic [7:0] addr, input logic [31:0] exp);
      logic [31:0] d;
      logic [1:0]  r;
      axi_read(addr, d, r);
      check(name, d, exp);
      check({name, "_resp"}, 32'(r), 32'(RESP_OKAY));
   endtask

   initial begin
      logic [31:0] d;
      logic [1:0]  r;
      bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
      bus.wvalid = 1'b0; bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0;
      bus.rready = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_irq_out", 32'(irq_out), 32'd0);
      check("rst_arready", 32'(bus.arready), 32'd0);
      check("rst_bvalid", 32'(bus.bvalid), 32'd0);
      check("rst_rvalid", 32'(bus.rvalid), 32'd0);
      check("rst_rdata", bus.rdata, 32'd0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      tick();
      rd("rst_pending", 8'h00, 32'h0);
      rd("rst_enable", 8'h04, 32'h0);
      rd("rst_mode", 8'h08, 32'h0);
      rd("rst_pol", 8'h0C, 32'h0);
      rd("rst_claim", 8'h10, 32'h0);
      rd("rst_raw", 8'h14, 32'h0);

      // All lines high with nothing enabled
      irq_in = 8'hFF;
      repeat (5) tick();
      check("ff_disabled_irq", 32'(irq_out), 32'd0);
      rd("ff_raw", 8'h14, 32'hFF);
      rd("ff_level_pending", 8'h00, 32'hFF);
      irq_in = 8'h00;
      repeat (4) tick();

      // Byte strobes: only lanes with a strobe update
      axi_write(8'h04, 32'h0000_FFFF, 4'b0010, 0, r);
      rd("strb_hi_only", 8'h04, 32'h0);
      axi_write(8'h04, 32'h0000_00AB, 4'b0000, 0, r);
      rd("strb_none", 8'h04, 32'h0);

      // Edge line 3: latency and claim
      wr(8'h04, 32'h08);
      wr(8'h08, 32'h08);
      irq_in = 8'h08;
      tick();
      irq_in = 8'h00;
      tick();
      tick();
      check("lat_irq_c3_low", 32'(irq_out), 32'd0);
      rd("lat_pending_c3", 8'h00, 32'h08);
      check("lat_irq_c4_high", 32'(irq_out), 32'd1);
      rd("claim_line3", 8'h10, 32'd4);
      check("claim_irq_drop", 32'(irq_out), 32'd0);
      rd("after_claim_pend", 8'h00, 32'h0);

      // Level line 1, active-low
      wr(8'h0C, 32'h02);
      rd("lvl_pending", 8'h00, 32'h02);
      wr(8'h00, 32'h02);
      rd("lvl_w1c_noeffect", 8'h00, 32'h02);
      irq_in = 8'h02;
      repeat (3) tick();
      rd("lvl_released", 8'h00, 32'h0);

      // Edges on lines 2 and 5, claimed in index order
      wr(8'h08, 32'h2C);
      wr(8'h04, 32'h2C);
      irq_in = 8'h26;
      repeat (4) tick();
      check("two_irq_high", 32'(irq_out), 32'd1);
      rd("claim_first", 8'h10, 32'd3);
      check("irq_after_1st", 32'(irq_out), 32'd1);
      rd("claim_second", 8'h10, 32'd6);
      check("irq_after_2nd", 32'(irq_out), 32'd0);
      rd("claim_none", 8'h10, 32'd0);
      irq_in = 8'h02;

      // Set beats a simultaneous W1C on line 0
      wr(8'h08, 32'h2D);
      wr(8'h04, 32'h2D);
      irq_in = 8'h03;
      tick();
      tick();
      wr(8'h00, 32'h01);
      rd("set_wins_w1c", 8'h00, 32'h01);
      rd("claim_line0", 8'h10, 32'd1);
      rd("line0_cleared", 8'h00, 32'h0);
      irq_in = 8'h02;

      // Unmapped accesses
      axi_write(8'h18, 32'hFFFF_FFFF, 4'hF, 5, r);
      check("unmapped_bresp", 32'(r), 32'(RESP_SLVERR));
      rd("unmapped_no_en", 8'h04, 32'h2D);
      rd("unmapped_no_mode", 8'h08, 32'h2D);
      rd("unmapped_no_pol", 8'h0C, 32'h02);
      axi_read(8'h1C, d, r);
      check("unmapped_rdata", d, 32'h0);
      check("unmapped_rresp", 32'(r), 32'(RESP_SLVERR));
      rd("raw_low_bits_ignored", 8'h16, 32'h02);

      repeat (3) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/holy_irq_ctrl.md
Name: holy_irq_ctrl

Overview:
- Parametrised external-interrupt controller between the SoC `irq_in` pins and the Holy Core machine-external interrupt input.
- Generalises the fixed 2-line `irq_in` to NUM_IRQ lines.
- Per line: synchronisation, enable, level/edge mode and polarity, plus pending/claim registers on an AXI-Lite slave.
- Produces one registered `irq_out` to the core.

Parameters:
- NUM_IRQ, 8, number of interrupt lines; legal range 1..31.
- SYNC_STAGES, 2, synchroniser flops per line; minimum 2.
- ADDR_WIDTH, 8, AXI-Lite address width. Only bits [4:2] are decoded; bits [1:0] are ignored.

Ports:
- clk  in  1  core clock; all logic is on this clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- irq_in  in  NUM_IRQ  raw asynchronous interrupt lines.
- irq_out  out  1  registered OR of (pending & enable).
- s_axi_lite_awaddr  in  ADDR_WIDTH; s_axi_lite_awvalid in 1; s_axi_lite_awready out 1.
- s_axi_lite_wdata  in  32; s_axi_lite_wstrb in 4; s_axi_lite_wvalid in 1; s_axi_lite_wready out 1.
- s_axi_lite_bresp  out  2; s_axi_lite_bvalid out 1; s_axi_lite_bready in 1.
- s_axi_lite_araddr  in  ADDR_WIDTH; s_axi_lite_arvalid in 1; s_axi_lite_arready out 1.
- s_axi_lite_rdata  out  32; s_axi_lite_rresp out 2; s_axi_lite_rvalid out 1; s_axi_lite_rready in 1.

Behaviour:
- Reset:
  - All registers, synchroniser flops and edge-history flops clear to 0.
  - irq_out, awready, wready, bvalid, arready and rvalid are 0; bresp, rresp and rdata are 0.
- Register map (bits above NUM_IRQ-1 read 0 and ignore writes):
  - 0x00 PENDING: read; write-1-to-clear, edge lines only.
  - 0x04 ENABLE: RW.
  - 0x08 MODE: RW; 1 = edge, 0 = level.
  - 0x0C POLARITY: RW; 1 = active-low.
  - 0x10 CLAIM: read-only. Returns (lowest index i with pending[i] & enable[i]) + 1, or 0 if none. The read clears pending[i] if line i is edge mode.
  - 0x14 RAW: read-only; synchronised irq_in before polarity.
  - Unmapped offsets: reads return 0 with SLVERR (2'b10); writes are ignored and answered with SLVERR.
- Byte strobes: RW registers are updated per wstrb byte. For PENDING W1C, only bytes with their strobe set participate.
- Line path:
  - s = sync(irq_in) XOR polarity.
  - Level mode: pending[i] = s[i], combinational from the registered s; W1C and claim have no effect.
  - Edge mode: set = s & ~s_prev, where s_prev is registered each cycle.
- Pending update each cycle, edge lines: pending_next = (pending & ~w1c & ~claim_clr) | set. Set wins over a simultaneous clear.
- irq_out is registered: irq_out_next = |(pending & enable).
- Latency: a rising edge on irq_in before clock edge 0 (edge mode, enabled, polarity 0):
  - s high after edge SYNC_STAGES-1;
  - pending high after edge SYNC_STAGES;
  - irq_out high after edge SYNC_STAGES+1.
  - With defaults: pending visible at cycle 3, irq_out at cycle 4.
- Writes to POLARITY or MODE may generate a spurious edge. This is defined behaviour; software clears PENDING afterwards.
- Write channel:
  - One outstanding write. awready and wready assert together, for one cycle, only when awvalid & wvalid & ~bvalid.
  - The register update and bvalid occur on that same edge; bresp = OKAY or SLVERR.
  - bvalid is held until bready.
- Read channel:
  - One outstanding read. arready = ~rvalid; on the arvalid & arready handshake, rdata/rresp are registered and rvalid rises the next cycle.
  - rvalid is held until rready; rdata is stable while rvalid.
  - The CLAIM side effect is applied on the ar handshake edge, exactly once per read.
- Read and write channels are independent. A simultaneous CLAIM read and PENDING W1C are both applied, OR-ed into the clear mask.
- rst_n asserted mid-transaction aborts it. No response is issued after reset release.

Decomposition:
- holy_irq_pkg:
  - register offset localparams (PENDING_OFF .. RAW_OFF);
  - AXI response constants RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10.
- Sub-module holy_irq_sync: parametrised SYNC_STAGES x NUM_IRQ flop chain with async active-low reset. It is instantiated once.
- Priority encoder, edge logic and AXI-Lite slave live in holy_irq_ctrl.

Test Plan:
- Reset, then read all six offsets -> rdata 0, rresp OKAY. irq_out = 0 with irq_in = 8'hFF while ENABLE = 0.
- ENABLE = 8'h08, MODE = 8'h08, pulse irq_in[3] high for 1 cycle -> PENDING = 8'h08 at cycle 3, irq_out = 1 at cycle 4. CLAIM reads 4, then PENDING = 0 and irq_out = 0 one cycle later.
- Level mode line 1, POLARITY = 8'h02, irq_in[1] = 0 -> PENDING bit1 = 1. W1C 8'h02 -> bit stays 1. Drive irq_in[1] = 1 -> bit clears after 3 cycles.
- Edges on lines 2 and 5, both enabled -> CLAIM = 3, then 6, then 0. irq_out drops after the second claim.
- W1C of bit 0 on the same cycle a new edge sets bit 0 -> PENDING bit0 remains 1.
- Write to 0x18 with bready held low 5 cycles -> bvalid stays high with bresp = 2'b10, no register changes. Read of 0x1C -> rresp = 2'b10, rdata = 0.
